csr_trap_seq: RTL and testbench

Memory/writeback-side sequencer that drives the CSR register file's single write port (`MD_need_CSR`, `MD_csr_addr`, `MD_csr_valE`) and produces the trap redirect.

- Ordinary CSR writes pass straight through.
- `ecall` and `mret` need several CSR updates. The write port accepts one write per cycle, so this block serialises those updates with a small FSM.
- While it does so it stalls the upstream pipeline, then issues a PC redirect and a flush.

---
 rtl/csr_trap_seq_pkg.sv | 31 +++
 rtl/csr_trap_seq_mstatus_xform.sv | 27 ++
 rtl/csr_trap_seq.sv | 148 ++++++++++++++
 tb/tb_csr_trap_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_seq_pkg.sv
// Shared CSR numbering, mstatus field positions and sequencer state encoding
// for the trap sequencer and the CSR register file.
package csr_trap_seq_pkg;

   localparam int unsigned CSR_WIDTH        = 2;
   localparam int unsigned CSR_NUMBER_WIDTH = 12;

   // Bit indices inside the one-hot CSR op vector
   localparam int unsigned CSR_OP_ECALL = 0;
   localparam int unsigned CSR_OP_MRET  = 1;

   localparam logic [CSR_NUMBER_WIDTH-1:0] CSR_MSTATUS = 12'h300;
   localparam logic [CSR_NUMBER_WIDTH-1:0] CSR_MTVEC   = 12'h305;
   localparam logic [CSR_NUMBER_WIDTH-1:0] CSR_MEPC    = 12'h341;
   localparam logic [CSR_NUMBER_WIDTH-1:0] CSR_MCAUSE  = 12'h342;

   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      EC_MEPC   = 3'd1,
      EC_MCAUSE = 3'd2,
      EC_MSTAT  = 3'd3,
      MR_MSTAT  = 3'd4,
      REDIR     = 3'd5
   } trap_state_e;

endpackage

// File: rtl/csr_trap_seq_mstatus_xform.sv
// Trap-entry and trap-return rewrites of mstatus (MIE/MPIE/MPP fields only;
// every other bit passes through untouched).
module mstatus_xform
   import csr_trap_seq_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] mstatus,
   output logic [XLEN-1:0] mstatus_entry,
   output logic [XLEN-1:0] mstatus_return
);

   always_comb begin
      // NOTE: full-vector defaults first so no path through the block can infer a latch.
      mstatus_entry  = mstatus;
      mstatus_return = mstatus;

      mstatus_entry[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
      mstatus_entry[MSTATUS_MIE]                   = 1'b0;
      mstatus_entry[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

      mstatus_return[MSTATUS_MIE]                   = mstatus[MSTATUS_MPIE];
      mstatus_return[MSTATUS_MPIE]                  = 1'b1;
      mstatus_return[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

endmodule

// File: rtl/csr_trap_seq.sv
// Serialises the multi-CSR updates of ecall/mret onto the single CSR write
// port, stalling upstream meanwhile, then redirects fetch and flushes.
module csr_trap_seq
   import csr_trap_seq_pkg::*;
#(
   parameter int unsigned         XLEN        = 32,
   parameter logic [XLEN-1:0]     ECALL_CAUSE = XLEN'(32'hb)
) (
   input  logic                        clk_i,
   input  logic                        rst,
   input  logic                        M_valid_i,
   input  logic [CSR_WIDTH-1:0]        M_csr_op_i,
   input  logic [XLEN-1:0]             M_pc_i,
   input  logic                        M_csr_we_i,
   input  logic [CSR_NUMBER_WIDTH-1:0] M_csr_addr_i,
   input  logic [XLEN-1:0]             M_csr_wdata_i,
   input  logic [XLEN-1:0]             csr_mstatus_i,
   input  logic [XLEN-1:0]             csr_mtvec_i,
   input  logic [XLEN-1:0]             csr_mepc_i,
   output logic                        MD_need_CSR_o,
   output logic [CSR_NUMBER_WIDTH-1:0] MD_csr_addr_o,
   output logic [XLEN-1:0]             MD_csr_valE_o,
   output logic                        stall_o,
   output logic                        flush_o,
   output logic                        redirect_valid_o,
   output logic [XLEN-1:0]             redirect_pc_o
);

   trap_state_e     state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] mstatus_q;
   logic [XLEN-1:0] target_q;
   logic            ecall_q;
   logic [XLEN-1:0] mstatus_entry;
   logic [XLEN-1:0] mstatus_return;
   logic            accept_ecall;
   logic            accept_mret;

   // ecall takes priority when both op bits are set
   assign accept_ecall = (state_q == IDLE) && M_valid_i && M_csr_op_i[CSR_OP_ECALL];
   assign accept_mret  = (state_q == IDLE) && M_valid_i && M_csr_op_i[CSR_OP_MRET]
                         && !M_csr_op_i[CSR_OP_ECALL];

   mstatus_xform #(.XLEN(XLEN)) u_mstatus_xform (
      .mstatus        (mstatus_q),
      .mstatus_entry  (mstatus_entry),
      .mstatus_return (mstatus_return)
   );

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         mstatus_q <= '0;
         target_q  <= '0;
         ecall_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept_ecall) begin
            pc_q      <= M_pc_i;
            mstatus_q <= csr_mstatus_i;
            target_q  <= csr_mtvec_i;
            ecall_q   <= 1'b1;
         end else if (accept_mret) begin
            mstatus_q <= csr_mstatus_i;
            target_q  <= csr_mepc_i;
            ecall_q   <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      MD_need_CSR_o    = 1'b0;
      MD_csr_addr_o    = '0;
      MD_csr_valE_o    = '0;
      stall_o          = 1'b0;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;

      unique case (state_q)
         IDLE: begin
            if (accept_ecall) begin
               stall_o = 1'b1;
               state_d = EC_MEPC;
            end else if (accept_mret) begin
               stall_o = 1'b1;
               state_d = MR_MSTAT;
            end else if (M_valid_i) begin
               MD_need_CSR_o = M_csr_we_i;
               MD_csr_addr_o = M_csr_addr_i;
               MD_csr_valE_o = M_csr_wdata_i;
            end
         end
         EC_MEPC: begin
            MD_need_CSR_o = 1'b1;
            MD_csr_addr_o = CSR_MEPC;
            MD_csr_valE_o = pc_q;
            stall_o       = 1'b1;
            state_d       = EC_MCAUSE;
         end
         EC_MCAUSE: begin
            MD_need_CSR_o = 1'b1;
            MD_csr_addr_o = CSR_MCAUSE;
            MD_csr_valE_o = ECALL_CAUSE;
            stall_o       = 1'b1;
            state_d       = EC_MSTAT;
         end
         EC_MSTAT: begin
            MD_need_CSR_o = 1'b1;
            MD_csr_addr_o = CSR_MSTATUS;
            MD_csr_valE_o = mstatus_entry;
            stall_o       = 1'b1;
            state_d       = REDIR;
         end
         MR_MSTAT: begin
            MD_need_CSR_o = 1'b1;
            MD_csr_addr_o = CSR_MSTATUS;
            MD_csr_valE_o = mstatus_return;
            stall_o       = 1'b1;
            state_d       = REDIR;
         end
         REDIR: begin
            flush_o          = 1'b1;
            redirect_valid_o = 1'b1;
            // mtvec is honoured in direct mode only, so its mode bits are dropped
            redirect_pc_o    = ecall_q ? {target_q[XLEN-1:2], 2'b00} : target_q;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are silent while reset is held, even though M inputs may be live
      if (rst) begin
         state_d          = IDLE;
         MD_need_CSR_o    = 1'b0;
         MD_csr_addr_o    = '0;
         MD_csr_valE_o    = '0;
         stall_o          = 1'b0;
         flush_o          = 1'b0;
         redirect_valid_o = 1'b0;
         redirect_pc_o    = '0;
      end
   end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed bench for csr_trap_seq: pass-through, ecall/mret sequences,
// conflicts, back-to-back traps, reset abort and invalid slot.
module tb_csr_trap_seq;
   import csr_trap_seq_pkg::*;

   logic                        clk_i = 1'b0;
   logic                        rst;
   logic                        M_valid_i;
   logic [CSR_WIDTH-1:0]        M_csr_op_i;
   logic [31:0]                 M_pc_i;
   logic                        M_csr_we_i;
   logic [CSR_NUMBER_WIDTH-1:0] M_csr_addr_i;
   logic [31:0]                 M_csr_wdata_i;
   logic [31:0]                 csr_mstatus_i;
   logic [31:0]                 csr_mtvec_i;
   logic [31:0]                 csr_mepc_i;
   logic                        MD_need_CSR_o;
   logic [CSR_NUMBER_WIDTH-1:0] MD_csr_addr_o;
   logic [31:0]                 MD_csr_valE_o;
   logic                        stall_o;
   logic                        flush_o;
   logic                        redirect_valid_o;
   logic [31:0]                 redirect_pc_o;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [CSR_WIDTH-1:0] OP_NONE  = '0;
   localparam logic [CSR_WIDTH-1:0] OP_ECALL = CSR_WIDTH'(1 << CSR_OP_ECALL);
   localparam logic [CSR_WIDTH-1:0] OP_MRET  = CSR_WIDTH'(1 << CSR_OP_MRET);

   csr_trap_seq #(.XLEN(32), .ECALL_CAUSE(32'hb)) dut (
      .clk_i            (clk_i),
      .rst              (rst),
      .M_valid_i        (M_valid_i),
      .M_csr_op_i       (M_csr_op_i),
      .M_pc_i           (M_pc_i),
      .M_csr_we_i       (M_csr_we_i),
      .M_csr_addr_i     (M_csr_addr_i),
      .M_csr_wdata_i    (M_csr_wdata_i),
      .csr_mstatus_i    (csr_mstatus_i),
      .csr_mtvec_i      (csr_mtvec_i),
      .csr_mepc_i       (csr_mepc_i),
      .MD_need_CSR_o    (MD_need_CSR_o),
      .MD_csr_addr_o    (MD_csr_addr_o),
      .MD_csr_valE_o    (MD_csr_valE_o),
      .stall_o          (stall_o),
      .flush_o          (flush_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Write port: strobe, plus address/data whenever a write is expected
   task automatic chk_wr(input string tag, input logic need, input logic [11:0] addr,
                         input logic [31:0] data);
      check({tag, ".need"}, {31'b0, MD_need_CSR_o}, {31'b0, need});
      if (need) begin
         check({tag, ".addr"}, {20'b0, MD_csr_addr_o}, {20'b0, addr});
         check({tag, ".data"}, MD_csr_valE_o, data);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic stall, input logic redir,
                          input logic [31:0] pc);
      check({tag, ".stall"}, {31'b0, stall_o}, {31'b0, stall});
      check({tag, ".flush"}, {31'b0, flush_o}, {31'b0, redir});
      check({tag, ".redir"}, {31'b0, redirect_valid_o}, {31'b0, redir});
      if (redir) check({tag, ".rpc"}, redirect_pc_o, pc);
   endtask

   task automatic m_in(input logic v, input logic [CSR_WIDTH-1:0] op, input logic [31:0] pc,
                       input logic we, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
      M_valid_i     = v;
      M_csr_op_i    = op;
      M_pc_i        = pc;
      M_csr_we_i    = we;
      M_csr_addr_i  = addr;
      M_csr_wdata_i = wd;
      csr_mstatus_i = ms;
      csr_mtvec_i   = tv;
      csr_mepc_i    = ep;
   endtask

   task automatic idle_in();
      m_in(1'b0, OP_NONE, 32'h0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   // Advance to just after the next rising edge; checks follow a short settle
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // Reset with live, write-requesting inputs: outputs must stay 0
      rst = 1'b1;
      m_in(1'b1, OP_NONE, 32'h10, 1'b1, 12'h305, 32'h1234, 32'h8, 32'h100, 32'h0);
      tick(); tick();
      #2;
      chk_wr("rst_hold", 1'b0, 12'h0, 32'h0);
      chk_ctl("rst_hold", 1'b0, 1'b0, 32'h0);
      tick();
      rst = 1'b0;
      idle_in();
      #2;
      chk_wr("post_rst", 1'b0, 12'h0, 32'h0);
      chk_ctl("post_rst", 1'b0, 1'b0, 32'h0);

      // Ordinary CSR write passes straight through
      tick();
      m_in(1'b1, OP_NONE, 32'h20, 1'b1, 12'h305, 32'h8000_0100, 32'h0, 32'h0, 32'h0);
      #2;
      chk_wr("pass", 1'b1, 12'h305, 32'h8000_0100);
      chk_ctl("pass", 1'b0, 1'b0, 32'h0);
      tick();
      m_in(1'b1, OP_NONE, 32'h24, 1'b0, 12'h341, 32'hdead_beef, 32'h0, 32'h0, 32'h0);
      #2;
      chk_wr("pass_nowe", 1'b0, 12'h0, 32'h0);

      // ecall with a conflicting write request
      tick();
      m_in(1'b1, OP_ECALL, 32'h40, 1'b1, 12'h305, 32'hffff_ffff, 32'h1808, 32'h203, 32'h0);
      #2;
      chk_wr("ec_T0", 1'b0, 12'h0, 32'h0);
      chk_ctl("ec_T0", 1'b1, 1'b0, 32'h0);
      tick();
      // Junk trap requests while busy must be ignored
      m_in(1'b1, OP_MRET, 32'h99, 1'b1, 12'h305, 32'h5555, 32'hffff_ffff, 32'h0, 32'h7000);
      #2;
      chk_wr("ec_T1", 1'b1, 12'h341, 32'h40);
      chk_ctl("ec_T1", 1'b1, 1'b0, 32'h0);
      tick();
      #2;
      chk_wr("ec_T2", 1'b1, 12'h342, 32'hb);
      chk_ctl("ec_T2", 1'b1, 1'b0, 32'h0);
      tick();
      #2;
      chk_wr("ec_T3", 1'b1, 12'h300, 32'h1880);
      chk_ctl("ec_T3", 1'b1, 1'b0, 32'h0);
      tick();
      idle_in();
      #2;
      chk_wr("ec_T4", 1'b0, 12'h0, 32'h0);
      chk_ctl("ec_T4", 1'b0, 1'b1, 32'h200);
      tick();
      #2;
      chk_wr("ec_T5", 1'b0, 12'h0, 32'h0);
      chk_ctl("ec_T5", 1'b0, 1'b0, 32'h0);

      // mret
      tick();
      m_in(1'b1, OP_MRET, 32'h60, 1'b0, 12'h0, 32'h0, 32'h1880, 32'h0, 32'h44);
      #2;
      chk_wr("mr_T0", 1'b0, 12'h0, 32'h0);
      chk_ctl("mr_T0", 1'b1, 1'b0, 32'h0);
      tick();
      idle_in();
      #2;
      chk_wr("mr_T1", 1'b1, 12'h300, 32'h1888);
      chk_ctl("mr_T1", 1'b1, 1'b0, 32'h0);
      tick();
      #2;
      chk_wr("mr_T2", 1'b0, 12'h0, 32'h0);
      chk_ctl("mr_T2", 1'b0, 1'b1, 32'h44);

      // Both op bits set: ecall wins
      tick();
      m_in(1'b1, OP_ECALL | OP_MRET, 32'h80, 1'b0, 12'h0, 32'h0, 32'h8, 32'h100, 32'h4444);
      #2;
      chk_ctl("both_T0", 1'b1, 1'b0, 32'h0);
      tick();
      idle_in();
      #2;
      chk_wr("both_T1", 1'b1, 12'h341, 32'h80);
      tick();
      #2;
      chk_wr("both_T2", 1'b1, 12'h342, 32'hb);
      tick();
      #2;
      chk_wr("both_T3", 1'b1, 12'h300, 32'h1880);
      tick();
      // ecall presented during REDIR is ignored
      m_in(1'b1, OP_ECALL, 32'hc0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h300, 32'h0);
      #2;
      chk_ctl("both_T4", 1'b0, 1'b1, 32'h100);

      // Back-to-back: mret in the cycle right after REDIR is accepted
      tick();
      m_in(1'b1, OP_MRET, 32'h88, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 32'h84);
      #2;
      chk_wr("b2b_T0", 1'b0, 12'h0, 32'h0);
      chk_ctl("b2b_T0", 1'b1, 1'b0, 32'h0);
      tick();
      idle_in();
      #2;
      chk_wr("b2b_T1", 1'b1, 12'h300, 32'h1880);
      tick();
      #2;
      chk_ctl("b2b_T2", 1'b0, 1'b1, 32'h84);

      // Reset during an ecall sequence abandons it
      tick();
      m_in(1'b1, OP_ECALL, 32'h40, 1'b0, 12'h0, 32'h0, 32'h1808, 32'h203, 32'h0);
      tick();
      idle_in();
      #2;
      chk_wr("rmid_T1", 1'b1, 12'h341, 32'h40);
      tick();
      rst = 1'b1;
      #2;
      chk_wr("rmid_T2", 1'b0, 12'h0, 32'h0);
      chk_ctl("rmid_T2", 1'b0, 1'b0, 32'h0);
      tick();
      rst = 1'b0;
      #2;
      chk_wr("rmid_T3", 1'b0, 12'h0, 32'h0);
      chk_ctl("rmid_T3", 1'b0, 1'b0, 32'h0);
      tick();
      #2;
      chk_wr("rmid_T4", 1'b0, 12'h0, 32'h0);
      chk_ctl("rmid_T4", 1'b0, 1'b0, 32'h0);
      // FSM must be back in IDLE: an ordinary write passes through again
      tick();
      m_in(1'b1, OP_NONE, 32'h50, 1'b1, 12'h342, 32'h77, 32'h0, 32'h0, 32'h0);
      #2;
      chk_wr("rmid_idle", 1'b1, 12'h342, 32'h77);

      // Invalid slot with ecall bit and write request set
      tick();
      m_in(1'b0, OP_ECALL, 32'h40, 1'b1, 12'h305, 32'h1, 32'h1808, 32'h203, 32'h0);
      #2;
      chk_wr("inv_T0", 1'b0, 12'h0, 32'h0);
      chk_ctl("inv_T0", 1'b0, 1'b0, 32'h0);
      tick();
      idle_in();
      #2;
      chk_wr("inv_T1", 1'b0, 12'h0, 32'h0);
      chk_ctl("inv_T1", 1'b0, 1'b0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
